// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - fetch-address generator bus: stall, EX resolution in, fetch/prediction out
interface pc_unit_if #(
    parameter int XLEN       = 32,
    parameter int MISP_CNT_W = 16
);
    logic                  load_stall;
    logic                  ex_valid;
    logic                  ex_is_cti;
    logic [XLEN-1:0]       ex_pc;
    logic                  ex_taken;
    logic [XLEN-1:0]       ex_target;
    logic                  ex_pred_taken;
    logic [XLEN-1:0]       ex_pred_target;
    logic [XLEN-1:0]       pc;
    logic                  pred_taken;
    logic [XLEN-1:0]       pred_target;
    logic                  flush;
    logic [MISP_CNT_W-1:0] misp_cnt;

    // Pipeline side: drives hazard and EX resolution, consumes fetch address
    modport master (
        output load_stall, ex_valid, ex_is_cti, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        input  pc, pred_taken, pred_target, flush, misp_cnt
    );

    // PC unit side
    modport slave (
        input  load_stall, ex_valid, ex_is_cti, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        output pc, pred_taken, pred_target, flush, misp_cnt
    );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - RV32 fetch PC register with next-PC selection; BTB built only when PC_UNIT_BTB_EN is defined
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BTB_DEPTH    = 16,
    parameter int              MISP_CNT_W   = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    pc_unit_if.slave  bus
);
    logic                  mispredict;
    logic [XLEN-1:0]       pc_q, pc_d;
    logic [XLEN-1:0]       pc_plus4;
    logic [XLEN-1:0]       ex_plus4;
    logic                  pred_taken;
    logic [XLEN-1:0]       pred_target;
    logic [MISP_CNT_W-1:0] misp_cnt_q, misp_cnt_d;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign ex_plus4 = bus.ex_pc + XLEN'(4);

    // A resolved CTI disagrees with the prediction it carried (direction, or target when both taken)
    always_comb begin
        mispredict = 1'b0;
        if (bus.ex_valid && bus.ex_is_cti) begin
            mispredict = (bus.ex_taken != bus.ex_pred_taken) ||
                         (bus.ex_taken && bus.ex_pred_taken &&
                          (bus.ex_target != bus.ex_pred_target));
        end
    end

`ifdef PC_UNIT_BTB_EN
    localparam int IDX   = $clog2(BTB_DEPTH);
    localparam int TAG_W = XLEN - IDX - 2;

    logic             valid_q [BTB_DEPTH];
    logic [TAG_W-1:0] tag_q   [BTB_DEPTH];
    logic [XLEN-1:0]  tgt_q   [BTB_DEPTH];
    logic [1:0]       ctr_q   [BTB_DEPTH];

    logic [IDX-1:0]   rd_idx, wr_idx;
    logic             rd_hit, wr_hit;

    assign rd_idx = pc_q[IDX+1:2];
    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == pc_q[XLEN-1:IDX+2]);
    assign wr_idx = bus.ex_pc[IDX+1:2];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == bus.ex_pc[XLEN-1:IDX+2]);

    // Lookup reads registered contents only, so a same-cycle training write is not bypassed
    assign pred_taken  = rd_hit && ctr_q[rd_idx][1];
    assign pred_target = tgt_q[rd_idx];

    // BTB training from EX; independent of load_stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (bus.ex_valid && bus.ex_is_cti) begin
            if (wr_hit) begin
                if (bus.ex_taken) begin
                    if (ctr_q[wr_idx] != 2'b11) ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'b01;
                    tgt_q[wr_idx] <= bus.ex_target;
                end else if (ctr_q[wr_idx] != 2'b00) begin
                    ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'b01;
                end
            end else if (bus.ex_taken) begin
                valid_q[wr_idx] <= 1'b1;
                tag_q[wr_idx]   <= bus.ex_pc[XLEN-1:IDX+2];
                tgt_q[wr_idx]   <= bus.ex_target;
                ctr_q[wr_idx]   <= 2'b10;
            end
        end
    end
`else
    // No predictor: always fall through, so every taken CTI redirects from EX
    assign pred_taken  = 1'b0;
    assign pred_target = pc_plus4;
`endif

    // Next-PC priority: redirect, stall, prediction, sequential; counter saturates
    always_comb begin
        pc_d       = pc_plus4;
        misp_cnt_d = misp_cnt_q;
        if (mispredict) begin
            pc_d = bus.ex_taken ? bus.ex_target : ex_plus4;
        end else if (bus.load_stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
        if (mispredict && (misp_cnt_q != {MISP_CNT_W{1'b1}})) begin
            misp_cnt_d = misp_cnt_q + MISP_CNT_W'(1);
        end
    end

    // PC and mispredict counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_VECTOR;
            misp_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            misp_cnt_q <= misp_cnt_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pred_taken  = pred_taken;
    assign bus.pred_target = pred_target;
    assign bus.flush       = mispredict;
    assign bus.misp_cnt    = misp_cnt_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - randomized self-checking bench for pc_unit against a behavioural fetch model
module tb_pc_unit;
    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int IDXW  = 4;
    localparam int CW    = 16;
    localparam int unsigned CNT_MAX = 65535;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_unit_if #(.XLEN(XLEN), .MISP_CNT_W(CW)) bus ();

    pc_unit #(
        .XLEN(XLEN), .RESET_VECTOR(32'h0), .BTB_DEPTH(DEPTH), .MISP_CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int passes = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    int unsigned m_cnt;
    bit          m_v   [DEPTH];
    logic [31:0] m_tag [DEPTH];
    logic [31:0] m_tgt [DEPTH];
    int          m_ctr [DEPTH];

    function automatic void model_reset();
        m_pc  = 32'h0;
        m_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_v[i] = 1'b0; m_tag[i] = 32'h0; m_tgt[i] = 32'h0; m_ctr[i] = 1;
        end
    endfunction

    function automatic void mpred(input logic [31:0] a, output bit t, output logic [31:0] g);
`ifdef PC_UNIT_BTB_EN
        int i;
        i = int'((a >> 2) % DEPTH);
        t = m_v[i] && (m_tag[i] == (a >> (IDXW + 2))) && (m_ctr[i] >= 2);
        g = m_tgt[i];
`else
        t = 1'b0;
        g = a + 32'd4;
`endif
    endfunction

    function automatic bit m_misp();
        return bus.ex_valid && bus.ex_is_cti &&
               ((bus.ex_taken != bus.ex_pred_taken) ||
                (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));
    endfunction

    // Advance model by one cycle using current stimulus, then clock the DUT
    task automatic tick();
        bit          mis, pt;
        logic [31:0] pg, nxt;
        mis = m_misp();
        mpred(m_pc, pt, pg);
        if (mis)                 nxt = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
        else if (bus.load_stall) nxt = m_pc;
        else if (pt)             nxt = pg;
        else                     nxt = m_pc + 32'd4;
        if (mis && m_cnt != CNT_MAX) m_cnt++;
`ifdef PC_UNIT_BTB_EN
        if (bus.ex_valid && bus.ex_is_cti) begin
            int i;
            i = int'((bus.ex_pc >> 2) % DEPTH);
            if (m_v[i] && m_tag[i] == (bus.ex_pc >> (IDXW + 2))) begin
                if (bus.ex_taken) begin
                    m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = bus.ex_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (bus.ex_taken) begin
                m_v[i] = 1'b1; m_tag[i] = bus.ex_pc >> (IDXW + 2);
                m_tgt[i] = bus.ex_target; m_ctr[i] = 2;
            end
        end
`endif
        m_pc = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.load_stall = 1'b0; bus.ex_valid = 1'b0; bus.ex_is_cti = 1'b0;
        bus.ex_pc = 32'h0; bus.ex_taken = 1'b0; bus.ex_target = 32'h0;
        bus.ex_pred_taken = 1'b0; bus.ex_pred_target = 32'h0;
    endtask

    task automatic ex_cti(input logic [31:0] epc, input bit tk, input logic [31:0] tgt,
                          input bit ptk, input logic [31:0] ptgt);
        bus.ex_valid = 1'b1; bus.ex_is_cti = 1'b1; bus.ex_pc = epc;
        bus.ex_taken = tk; bus.ex_target = tgt;
        bus.ex_pred_taken = ptk; bus.ex_pred_target = ptgt;
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'h4; exp_seq[1] = 32'h8; exp_seq[2] = 32'hC;
        idle();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        checks++; if (bus.pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); else passes++;
        checks++; if (bus.pred_taken !== 1'b0) $display("FAIL reset_pred: got %b want 0", bus.pred_taken); else passes++;
        checks++; if (bus.flush !== 1'b0) $display("FAIL reset_flush: got %b want 0", bus.flush); else passes++;
        checks++; if (bus.misp_cnt !== 16'h0) $display("FAIL reset_cnt: got %h want 0", bus.misp_cnt); else passes++;
        rst_n = 1'b1;
        tick(); tick();
        // asynchronous reset mid-cycle, away from any clock edge
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.pc !== 32'h0) $display("FAIL async_reset_pc: got %h want 0", bus.pc); else passes++;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.pc !== exp_seq[i]) $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.pc, exp_seq[i]); else passes++;
            checks++; if (bus.flush !== 1'b0 || bus.pred_taken !== 1'b0) $display("FAIL seq_flags[%0d]: flush %b pred %b want 0 0", i, bus.flush, bus.pred_taken); else passes++;
        end
    endtask

    task automatic test_stall();
        idle();
        tick();
        checks++; if (bus.pc !== 32'h10) $display("FAIL stall_start: got %h want 10", bus.pc); else passes++;
        bus.load_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.pc !== 32'h10) $display("FAIL stall_hold[%0d]: got %h want 10", i, bus.pc); else passes++;
        end
        bus.load_stall = 1'b0;
        tick();
        checks++; if (bus.pc !== 32'h14) $display("FAIL stall_release: got %h want 14", bus.pc); else passes++;
    endtask

    task automatic test_taken_branch();
        ex_cti(32'h20, 1'b1, 32'h100, 1'b0, 32'h24);
        #1;
        checks++; if (bus.flush !== 1'b1) $display("FAIL taken_flush: got %b want 1", bus.flush); else passes++;
        tick(); idle(); #1;
        checks++; if (bus.pc !== 32'h100) $display("FAIL taken_pc: got %h want 100", bus.pc); else passes++;
        checks++; if (bus.flush !== 1'b0) $display("FAIL taken_flush_off: got %b want 0", bus.flush); else passes++;
        checks++; if (bus.misp_cnt !== 16'd1) $display("FAIL taken_cnt: got %0d want 1", bus.misp_cnt); else passes++;
        ex_cti(32'h200, 1'b1, 32'h20, 1'b0, 32'h204);
        tick(); idle(); #1;
        checks++; if (bus.pc !== 32'h20) $display("FAIL refetch_pc: got %h want 20", bus.pc); else passes++;
`ifdef PC_UNIT_BTB_EN
        checks++; if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h100) $display("FAIL btb_pred: got %b %h want 1 100", bus.pred_taken, bus.pred_target); else passes++;
`else
        checks++; if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h24) $display("FAIL nobtb_pred: got %b %h want 0 24", bus.pred_taken, bus.pred_target); else passes++;
`endif
        checks++; if (bus.misp_cnt !== 16'd2) $display("FAIL refetch_cnt: got %0d want 2", bus.misp_cnt); else passes++;
    endtask

    task automatic test_not_taken_hit();
        ex_cti(32'h20, 1'b0, 32'h100, 1'b1, 32'h100);
        #1;
        checks++; if (bus.flush !== 1'b1) $display("FAIL nt_flush: got %b want 1", bus.flush); else passes++;
        tick(); idle(); #1;
        checks++; if (bus.pc !== 32'h24) $display("FAIL nt_pc: got %h want 24", bus.pc); else passes++;
        ex_cti(32'h200, 1'b1, 32'h20, 1'b0, 32'h204);
        tick(); idle(); #1;
        checks++; if (bus.pc !== 32'h20) $display("FAIL nt_refetch_pc: got %h want 20", bus.pc); else passes++;
        checks++; if (bus.pred_taken !== 1'b0) $display("FAIL nt_pred: got %b want 0", bus.pred_taken); else passes++;
        tick();
        checks++; if (bus.pc !== 32'h24) $display("FAIL nt_seq_pc: got %h want 24", bus.pc); else passes++;
    endtask

    task automatic test_redirect_vs_stall();
        ex_cti(32'h40, 1'b1, 32'h300, 1'b0, 32'h44);
        bus.load_stall = 1'b1;
        #1;
        checks++; if (bus.flush !== 1'b1) $display("FAIL rs_flush: got %b want 1", bus.flush); else passes++;
        tick(); idle(); #1;
        checks++; if (bus.pc !== 32'h300) $display("FAIL rs_pc: got %h want 300", bus.pc); else passes++;
    endtask

    task automatic test_wrap();
        ex_cti(32'h80, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h84);
        tick(); idle(); #1;
        checks++; if (bus.pc !== 32'hFFFF_FFFC) $display("FAIL wrap_start: got %h want fffffffc", bus.pc); else passes++;
        tick();
        checks++; if (bus.pc !== 32'h0) $display("FAIL wrap_pc: got %h want 0", bus.pc); else passes++;
    endtask

    task automatic test_random();
        logic [31:0] addrs [8];
        bit          pt;
        logic [31:0] pg;
        for (int i = 0; i < 8; i++) addrs[i] = 32'h40 * i + 32'h20;
        for (int n = 0; n < 400; n++) begin
            idle();
            bus.load_stall = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 2) != 0) begin
                bus.ex_valid  = 1'b1;
                bus.ex_is_cti = ($urandom_range(0, 5) != 0);
                bus.ex_pc     = addrs[$urandom_range(0, 7)];
                bus.ex_taken  = $urandom_range(0, 1);
                bus.ex_target = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                if ($urandom_range(0, 1) != 0) begin
                    mpred(bus.ex_pc, pt, pg);
                    bus.ex_pred_taken = pt; bus.ex_pred_target = pg;
                end else begin
                    bus.ex_pred_taken  = $urandom_range(0, 1);
                    bus.ex_pred_target = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                end
            end
            #1;
            mpred(m_pc, pt, pg);
            checks++; if (bus.flush !== m_misp()) $display("FAIL rnd_flush[%0d]: got %b want %b", n, bus.flush, m_misp()); else passes++;
            checks++; if (bus.pred_taken !== pt) $display("FAIL rnd_pred_taken[%0d]: got %b want %b", n, bus.pred_taken, pt); else passes++;
            if (pt) begin
                checks++; if (bus.pred_target !== pg) $display("FAIL rnd_pred_target[%0d]: got %h want %h", n, bus.pred_target, pg); else passes++;
            end
            tick();
            checks++; if (bus.pc !== m_pc) $display("FAIL rnd_pc[%0d]: got %h want %h", n, bus.pc, m_pc); else passes++;
            checks++; if (bus.misp_cnt !== CW'(m_cnt)) $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, bus.misp_cnt, m_cnt); else passes++;
        end
        idle();
    endtask

    task automatic test_saturation();
        ex_cti(32'h0, 1'b1, 32'h8, 1'b0, 32'h4);
        for (int n = 0; n < 70000 && m_cnt < CNT_MAX; n++) tick();
        checks++; if (m_cnt != CNT_MAX) $display("FAIL sat_reach: model count %0d want %0d", m_cnt, CNT_MAX); else passes++;
        checks++; if (bus.misp_cnt !== 16'hFFFF) $display("FAIL sat_at_max: got %h want ffff", bus.misp_cnt); else passes++;
        for (int n = 0; n < 3; n++) tick();
        checks++; if (bus.misp_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", bus.misp_cnt); else passes++;
        checks++; if (bus.flush !== 1'b1) $display("FAIL sat_flush: got %b want 1", bus.flush); else passes++;
        checks++; if (bus.pc !== 32'h8) $display("FAIL sat_pc: got %h want 8", bus.pc); else passes++;
        idle();
    endtask

    initial begin
        test_reset();
        test_stall();
        test_taken_branch();
        test_not_taken_hit();
        test_redirect_vs_stall();
        test_wrap();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
